// File: rtl/debug_pkg.sv
`default_nettype none
// ============================================================================
// Module      : debug_pkg
// Description : Shared word tags and controller states for the debug dump
//               engine.
// Revision    : 1.0 - initial release
// ============================================================================
package debug_pkg;

  // Word-type tags carried alongside every snapshot word
  localparam logic [1:0] TAG_PC  = 2'd0;
  localparam logic [1:0] TAG_CYC = 2'd1;
  localparam logic [1:0] TAG_RF  = 2'd2;
  localparam logic [1:0] TAG_DM  = 2'd3;

  // Dump controller states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRAIN  = 2'd1,
    STREAM = 2'd2
  } dump_state_t;

endpackage
`default_nettype wire

// File: rtl/dump_out_stage.sv
`default_nettype none
// ============================================================================
// Module      : dump_out_stage
// Description : Single-entry valid/ready output register carrying
//               {tag, last, data}. The parent only asserts load_i when the
//               entry is empty or is being accepted in the same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module dump_out_stage
  import debug_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic [1:0]        tag_i,
  input  logic              last_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              ready_i,
  output logic              valid_o,
  output logic [1:0]        tag_o,
  output logic              last_o,
  output logic [DATA_W-1:0] data_o
);

  logic              valid_q;
  logic [1:0]        tag_q;
  logic              last_q;
  logic [DATA_W-1:0] data_q;

  // Load a new word, or drop valid once the held word is taken; hold otherwise
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      tag_q   <= TAG_PC;
      last_q  <= 1'b0;
      data_q  <= '0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      tag_q   <= tag_i;
      last_q  <= last_i;
      data_q  <= data_i;
    end else if (valid_q && ready_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign tag_o   = tag_q;
  assign last_o  = last_q;
  assign data_o  = data_q;

endmodule
`default_nettype wire

// File: rtl/debug_dump.sv
`default_nettype none
// ============================================================================
// Module      : debug_dump
// Description : On request, halts the core and streams PC, cycle count, the
//               whole register file and a data-memory window over a
//               valid/ready port. Word index, address generation and the
//               controller live here; the output register is dump_out_stage.
// Revision    : 1.0 - initial release
// ============================================================================
module debug_dump
  import debug_pkg::*;
#(
  parameter int          DATA_W   = 32,
  parameter int          RF_DEPTH = 32,
  parameter int          DM_WORDS = 32,
  parameter logic [31:0] DM_BASE  = 32'h0,
  parameter int          CNT_W    = 32,
  localparam int         RF_AW    = (RF_DEPTH > 1) ? $clog2(RF_DEPTH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  output logic              busy_o,
  output logic              halt_o,
  input  logic [31:0]       pc_i,
  output logic [RF_AW-1:0]  rf_addr_o,
  input  logic [DATA_W-1:0] rf_data_i,
  output logic [31:0]       dm_addr_o,
  input  logic [DATA_W-1:0] dm_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [1:0]        out_tag_o,
  output logic              out_last_o
);

  localparam int N_WORDS = 2 + RF_DEPTH + DM_WORDS;
  localparam int IDX_W   = $clog2(N_WORDS + 1);

  localparam logic [IDX_W-1:0] IDX_CYC  = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_RF0  = IDX_W'(2);
  localparam logic [IDX_W-1:0] IDX_DM0  = IDX_W'(2 + RF_DEPTH);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_WORDS - 1);
  localparam logic [IDX_W-1:0] IDX_END  = IDX_W'(N_WORDS);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  dump_state_t      state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cyc_q;

  logic              w_busy;
  logic              w_accept;
  logic              w_load;
  logic              w_is_rf;
  logic              w_is_dm;
  logic [IDX_W-1:0]  w_rf_off;
  logic [IDX_W-1:0]  w_dm_off;
  logic [1:0]        w_tag;
  logic              w_last;
  logic [DATA_W-1:0] w_data;

  assign w_busy   = (state_q != IDLE);
  assign busy_o   = w_busy;
  assign halt_o   = w_busy;
  assign w_accept = out_valid_o && out_ready_i;
  // The DRAIN cycle ends with the PC load, so loading is allowed in DRAIN too
  assign w_load   = w_busy && (idx_q < IDX_END) && (!out_valid_o || w_accept);

  // Debug read addresses follow the index of the word about to be loaded
  assign w_is_rf   = (idx_q >= IDX_RF0) && (idx_q < IDX_DM0);
  assign w_is_dm   = (idx_q >= IDX_DM0) && (idx_q < IDX_END);
  assign w_rf_off  = idx_q - IDX_RF0;
  assign w_dm_off  = idx_q - IDX_DM0;
  assign rf_addr_o = w_is_rf ? RF_AW'(w_rf_off) : '0;
  assign dm_addr_o = w_is_dm ? (DM_BASE + (32'(w_dm_off) << 2)) : DM_BASE;

  // Select the word, its tag and the last flag for the current index
  always_comb begin
    w_tag  = TAG_PC;
    w_last = 1'b0;
    w_data = DATA_W'(pc_i);
    if (idx_q == IDX_CYC) begin
      w_tag  = TAG_CYC;
      w_data = DATA_W'(cyc_q);
    end else if (w_is_rf) begin
      w_tag  = TAG_RF;
      w_data = rf_data_i;
    end else if (w_is_dm) begin
      w_tag  = TAG_DM;
      w_data = dm_data_i;
      w_last = (idx_q == IDX_LAST);
    end
  end

  // Controller next state and word index
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    if (w_load) begin
      idx_d = idx_q + IDX_W'(1);
    end
    case (state_q)
      IDLE: begin
        idx_d = '0;
        if (start_i) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        state_d = STREAM;
      end
      STREAM: begin
        if (w_accept && out_last_o) begin
          state_d = IDLE;
          idx_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // Controller state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Free-running saturating cycle counter, frozen while the core is halted
  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_q <= '0;
    end else if (!w_busy && (cyc_q != CNT_MAX)) begin
      cyc_q <= cyc_q + CNT_W'(1);
    end
  end

  dump_out_stage #(
    .DATA_W (DATA_W)
  ) u_out_stage (
    .clk     (clk),
    .rst     (rst),
    .load_i  (w_load),
    .tag_i   (w_tag),
    .last_i  (w_last),
    .data_i  (w_data),
    .ready_i (out_ready_i),
    .valid_o (out_valid_o),
    .tag_o   (out_tag_o),
    .last_o  (out_last_o),
    .data_o  (out_data_o)
  );

endmodule
`default_nettype wire

// File: tb/tb_debug_dump.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_debug_dump
// Description : Scoreboard bench for debug_dump. A model process builds the
//               expected snapshot when a start is accepted; a monitor pops
//               and compares every accepted word. A second instance covers
//               counter saturation with a 4-bit counter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_debug_dump;
  import debug_pkg::*;

  localparam int          RF_DEPTH = 32;
  localparam int          DM_WORDS = 32;
  localparam int          N_WORDS  = 2 + RF_DEPTH + DM_WORDS;
  localparam logic [31:0] DM_BASE  = 32'h100;

  typedef struct packed {
    logic [1:0]  tag;
    logic        last;
    logic [31:0] data;
  } word_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        out_ready = 1'b1;
  logic [31:0] pc = 32'h40;
  logic        busy, halt, out_valid, out_last;
  logic [1:0]  out_tag;
  logic [31:0] out_data, dm_addr, rf_data, dm_data;
  logic [4:0]  rf_addr;

  logic [31:0] rf_mem [RF_DEPTH];
  logic [31:0] dm_mem [DM_WORDS];
  int          dm_j;

  // Behavioural register file and data memory behind the debug ports
  always_comb begin
    rf_data = rf_mem[rf_addr];
    dm_j    = int'((dm_addr - DM_BASE) >> 2);
    dm_data = 32'hDEAD_BEEF;
    if (dm_addr >= DM_BASE && dm_addr < DM_BASE + 32'(4 * DM_WORDS) && dm_addr[1:0] == 2'b00)
      dm_data = dm_mem[dm_j];
  end

  debug_dump #(
    .DATA_W(32), .RF_DEPTH(RF_DEPTH), .DM_WORDS(DM_WORDS), .DM_BASE(DM_BASE), .CNT_W(32)
  ) dut (
    .clk(clk), .rst(rst), .start_i(start), .busy_o(busy), .halt_o(halt), .pc_i(pc),
    .rf_addr_o(rf_addr), .rf_data_i(rf_data), .dm_addr_o(dm_addr), .dm_data_i(dm_data),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
    .out_tag_o(out_tag), .out_last_o(out_last)
  );

  // Saturation instance: tiny dump with a 4-bit counter
  logic        rst2 = 1'b1, start2 = 1'b0;
  logic        busy2, halt2, v2, l2;
  logic [1:0]  t2;
  logic [31:0] d2, dma2, rfd2, dmd2;
  logic [0:0]  rfa2;
  assign rfd2 = 32'h100 + 32'(rfa2);
  assign dmd2 = 32'h77 + dma2;

  debug_dump #(
    .DATA_W(32), .RF_DEPTH(2), .DM_WORDS(1), .DM_BASE(32'h0), .CNT_W(4)
  ) dut2 (
    .clk(clk), .rst(rst2), .start_i(start2), .busy_o(busy2), .halt_o(halt2), .pc_i(pc),
    .rf_addr_o(rfa2), .rf_data_i(rfd2), .dm_addr_o(dma2), .dm_data_i(dmd2),
    .out_valid_o(v2), .out_ready_i(1'b1), .out_data_o(d2),
    .out_tag_o(t2), .out_last_o(l2)
  );

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  word_t           exp_q[$];
  longint unsigned cyc_m = 0;
  int              busy_cycles = 0;

  task automatic push_dump();
    exp_q.push_back('{TAG_PC, 1'b0, pc});
    exp_q.push_back('{TAG_CYC, 1'b0, cyc_m[31:0]});
    for (int i = 0; i < RF_DEPTH; i++) exp_q.push_back('{TAG_RF, 1'b0, rf_mem[i]});
    for (int j = 0; j < DM_WORDS; j++) exp_q.push_back('{TAG_DM, (j == DM_WORDS - 1), dm_mem[j]});
  endtask

  // Inputs are stable at the falling edge; predict what the next rising edge does
  always @(negedge clk) begin
    if (rst) begin
      cyc_m = 0;
    end else begin
      if (!halt && cyc_m < 64'hFFFF_FFFF) cyc_m++;
      if (start && !busy) push_dump();
    end
    if (busy) busy_cycles++;
  end

  // ---------------- monitor ----------------
  word_t hold, got, e;
  logic  have_hold = 1'b0;
  int    words_seen = 0;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      have_hold = 1'b0;
    end else begin
      got = '{out_tag, out_last, out_data};
      if (have_hold) check("stall_hold", {31'd0, out_valid, got}, {31'd0, 1'b1, hold});
      have_hold = out_valid && !out_ready;
      hold      = got;
      if (out_valid && out_ready) begin
        words_seen++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL extra_word: got 0x%0h, expected no word", got);
        end else begin
          e = exp_q.pop_front();
          check("word", 64'(got), 64'(e));
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ready(input int mode, input int ph);
    case (mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ((ph % 4) == 0) || ((ph % 4) == 3);
      default: out_ready = ($urandom_range(0, 3) != 0);
    endcase
  endtask

  task automatic run_dump(input int mode, input int restart_at);
    int w0, ph, ok;
    w0 = words_seen;
    ph = 0;
    ok = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int t = 0; t < 1000; t++) begin
      set_ready(mode, ph);
      ph++;
      start = (t == restart_at);
      tick();
      if (!busy && exp_q.size() == 0) begin
        ok = 1;
        break;
      end
    end
    start = 1'b0;
    out_ready = 1'b1;
    check("dump_done", 64'(ok), 64'd1);
    check("word_count", 64'(words_seen - w0), 64'(N_WORDS));
  endtask

  task automatic randomize_state();
    for (int i = 0; i < RF_DEPTH; i++) rf_mem[i] = $urandom;
    for (int j = 0; j < DM_WORDS; j++) dm_mem[j] = $urandom;
    pc = $urandom & 32'hFFFF_FFFC;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  word_t w2 [8];
  int    n2;

  initial begin
    for (int i = 0; i < RF_DEPTH; i++) rf_mem[i] = 32'(i * 3);
    for (int j = 0; j < DM_WORDS; j++) dm_mem[j] = 32'hA000 + 32'(j);

    // Reset values
    repeat (3) tick();
    @(negedge clk);
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_halt", 64'(halt), 64'd0);
    check("rst_data", 64'(out_data), 64'd0);
    check("rst_tag", 64'(out_tag), 64'd0);
    check("rst_last", 64'(out_last), 64'd0);
    check("rst_rf_addr", 64'(rf_addr), 64'd0);
    check("rst_dm_addr", 64'(dm_addr), 64'(DM_BASE));
    tick();
    rst = 1'b0;

    // Full-rate dump after idle cycles
    repeat (9) tick();
    busy_cycles = 0;
    run_dump(0, -1);
    check("busy_cycles", 64'(busy_cycles), 64'(N_WORDS + 1));
    @(negedge clk);
    check("idle_rf_addr", 64'(rf_addr), 64'd0);
    check("idle_dm_addr", 64'(dm_addr), 64'(DM_BASE));
    tick();

    // Same contents with ready toggling 1,0,0,1
    repeat (3) tick();
    run_dump(1, -1);

    // Random contents, random backpressure, start re-pulsed mid-stream
    randomize_state();
    repeat ($urandom_range(1, 8)) tick();
    run_dump(2, 20);

    // Reset during word 20, then a fresh dump
    randomize_state();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int t = 0; t < 200 && words_seen % N_WORDS < 20; t++) tick();
    check("reached_word20", 64'(words_seen % N_WORDS), 64'd20);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("midrst_valid", 64'(out_valid), 64'd0);
    check("midrst_halt", 64'(halt), 64'd0);
    words_seen = 0;
    tick();
    repeat ($urandom_range(3, 15)) tick();
    run_dump(0, -1);

    // Two more randomized dumps
    for (int k = 0; k < 2; k++) begin
      randomize_state();
      repeat ($urandom_range(1, 10)) tick();
      run_dump(2, -1);
    end

    // Counter saturation on the 4-bit instance
    rst2 = 1'b0;
    repeat (20) tick();
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    n2 = 0;
    for (int t = 0; t < 40 && n2 < 5; t++) begin
      @(negedge clk);
      if (v2) begin
        if (n2 < 8) w2[n2] = '{t2, l2, d2};
        n2++;
      end
    end
    check("sat_count", 64'(n2), 64'd5);
    check("sat_pc", 64'(w2[0]), 64'({TAG_PC, 1'b0, pc}));
    check("sat_cyc", 64'(w2[1]), 64'({TAG_CYC, 1'b0, 32'd15}));
    check("sat_rf0", 64'(w2[2]), 64'({TAG_RF, 1'b0, 32'h100}));
    check("sat_rf1", 64'(w2[3]), 64'({TAG_RF, 1'b0, 32'h101}));
    check("sat_dm0", 64'(w2[4]), 64'({TAG_DM, 1'b1, 32'h77}));
    tick();
    repeat (3) tick();
    check("sat_idle", 64'(busy2), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/debug_dump.md
# debug_dump

Synthesizable state-dump engine that replaces bench-only hierarchical probing of the CPU. On request it halts the core and streams a snapshot over a valid/ready port: PC, elapsed cycle count, every register-file entry, then a window of data memory. It sits beside `Top`. It drives the register file's and data memory's debug read addresses and the core's global stall, and feeds a host link such as a UART bridge.

## Interface
- `DATA_W`, 32: snapshot word width, matching register and memory word width.
- `RF_DEPTH`, 32: register-file entries dumped, indices 0..RF_DEPTH-1; must be ≥1.
- `DM_WORDS`, 32: data-memory words dumped; must be ≥1.
- `DM_BASE`, 0: byte address of the first dumped memory word; word-aligned.
- `CNT_W`, 32: cycle-counter width; must be ≤ DATA_W.

- `clk`  in  1  single clock, all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  dump request, sampled only in IDLE.
- `busy`  out  1  high from the cycle after start is accepted until the last word is accepted.
- `halt`  out  1  core stall; same timing as `busy`.
- `pc`  in  32  core PC.
- `rf_addr`  out  $clog2(RF_DEPTH)  register-file debug read index.
- `rf_data`  in  DATA_W  combinational read of `rf_addr`.
- `dm_addr`  out  32  data-memory debug byte address.
- `dm_data`  in  DATA_W  combinational read of `dm_addr`.
- `out_valid`  out  1  output word present.
- `out_ready`  in  1  sink accepts the word.
- `out_data`  out  DATA_W  snapshot word.
- `out_tag`  out  2  word type: 0 = PC, 1 = cycle count, 2 = RF, 3 = DM.
- `out_last`  out  1  high with the final DM word only.

## Operation
- Reset values: state IDLE, `busy`=0, `halt`=0, `out_valid`=0, `out_data`=0, `out_tag`=0, `out_last`=0, cycle counter 0, word index 0.
- Cycle counter:
  - Increments on every edge where `rst`=0 and `halt`=0.
  - Saturates at all-ones; it does not wrap.
  - Emitted zero-extended to DATA_W.
- Word sequence is fixed, with N = 2 + RF_DEPTH + DM_WORDS:
  - index 0: PC.
  - index 1: cycle count.
  - indices 2..RF_DEPTH+1: RF[0..RF_DEPTH-1].
  - remaining indices: DM word j at byte address DM_BASE + 4·j, for j = 0..DM_WORDS-1.
- `rf_addr` and `dm_addr` are driven from the index of the word about to be loaded. When that word is not of their type, they hold 0 and DM_BASE respectively.
- States and transitions:
  - IDLE → DRAIN when `start`=1.
  - DRAIN → STREAM after exactly one cycle. The cycle lets the core's in-flight writeback land before anything is sampled.
  - STREAM → IDLE on acceptance of the word with `out_last`=1.
- Output stage is a one-entry register.
  - It loads the next word when it is empty, or when the current word is accepted (`out_valid`&`out_ready`) in the same cycle.
  - It clears `out_valid` when it is accepted and no words remain.
- While `out_valid`=1 and `out_ready`=0, `out_data`/`out_tag`/`out_last` hold stable.
- `start` while `busy` is ignored; requests are not queued.
- Reset mid-dump: everything returns to reset values on that edge and the partial stream is abandoned. `halt` drops in the same cycle.
- RF[0] is emitted as read; no forcing to zero.

## Timing
- `start` high at edge k gives `busy`/`halt` = 1 after edge k.
- The first word (PC) is valid after edge k+1.
- With `out_ready` held at 1:
  - one word per cycle;
  - the last word is valid after edge k+N;
  - `busy`/`halt`/`out_valid` fall after edge k+N+1.
- Every cycle with `out_ready`=0 while `out_valid`=1 adds one cycle. No word is dropped or duplicated.
- PC and the cycle count are sampled at the load edge k+1. The counter is frozen from edge k onward.

## Structure
- Shared package `debug_pkg` holds:
  - the tag constants TAG_PC, TAG_CYC, TAG_RF, TAG_DM;
  - the state enum IDLE/DRAIN/STREAM.
- One sub-module, `dump_out_stage`: a single-entry valid/ready register carrying {tag, last, data}.
- The index counter, address generation and FSM stay in `debug_dump`.

## Test plan
- Defaults, `out_ready`=1, `pc`=0x40, start after 10 idle cycles:
  - 66 words with tags 0, 1, 2×32, 3×32;
  - cycle word = 10;
  - `out_last` only on word 65;
  - `busy` high for exactly 67 cycles.
- RF[i]=i·3 and DM[j]=0xA000+j, DM_BASE=0x100:
  - RF words equal i·3;
  - `dm_addr` steps 0x100, 0x104, … 0x17C;
  - DM words equal 0xA000+j.
- `out_ready` toggles 1,0,0,1 repeatedly:
  - the stream content is identical to the test above;
  - `out_data` stays stable during every stall.
- `start` pulsed again mid-stream: no restart; exactly one 66-word stream.
- `rst` asserted during word 20: the next cycle shows `out_valid`=0 and `halt`=0. A fresh start then yields a cycle count of 0 plus the idle cycles since reset.
- CNT_W=4, 20 idle cycles: cycle word = 15 (saturated).
